// File: rtl/twiddle_fetch_ctrl.sv
`timescale 1ns/1ps
// Address sequencer for the real-part twiddle ROM with a credit-managed skid FIFO on the output.
// Optional build macro TW_LOOP_EN adds the `loop` input for continuous sweeps.
module twiddle_fetch_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16,
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base,
    input  logic [ADDR_W:0]          len,
`ifdef TW_LOOP_EN
    input  logic                     loop,
`endif
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic signed [DATA_W-1:0] rom_data,
    output logic signed [DATA_W-1:0] tw_data,
    output logic                     tw_valid,
    input  logic                     tw_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        base_q;
    logic [ADDR_W:0]          len_q;
    logic [ADDR_W:0]          issued;
    logic [ROM_LAT-1:0]       vld_p;
    logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         fifo_count;

    logic loop_en;
    logic push;
    logic pop;
    logic issue;
    logic last_issue;
    logic drained;
    int   inflight;
    int   committed;

`ifdef TW_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign tw_valid = (fifo_count != '0);
    assign tw_data  = mem[rd_ptr];

    // Credit counts words already in the FIFO plus reads in flight, net of this cycle's pop,
    // so a new read is only launched when its word is guaranteed a slot.
    always_comb begin
        pop      = tw_valid && tw_ready;
        push     = vld_p[ROM_LAT-1];
        inflight = 0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + int'(vld_p[i]);
        end
        committed  = int'(fifo_count) - int'(pop) + inflight + 1;
        issue      = (state == FETCH) && (issued != len_q) && (committed <= FIFO_DEPTH);
        last_issue = ((issued + (ADDR_W+1)'(1)) == len_q);
        drained    = (inflight == 0) &&
                     ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
    end

    // rom_addr always holds the address the ROM samples on the next edge; it advances on
    // each issue and parks on the final address once the sweep has been issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        len_q  <= len;
                        issued <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            rom_addr <= base;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (last_issue && loop_en) begin
                            issued   <= '0;
                            rom_addr <= base_q;
                        end else if (last_issue) begin
                            issued <= issued + (ADDR_W+1)'(1);
                            state  <= DRAIN;
                        end else begin
                            issued   <= issued + (ADDR_W+1)'(1);
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ROM return pipe: vld_p[ROM_LAT-1] marks the cycle in which rom_data carries a fetched word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= rom_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for twiddle_fetch_ctrl: table of sweeps scored against a ROM model,
// plus hand-written reset-abort sequence.
module tb_twiddle_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  base;
    logic [5:0]  len;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] tw_data;
    logic        tw_valid;
    logic        tw_ready;
    logic        busy;
    logic        done;
`ifdef TW_LOOP_EN
    logic        loop_drv;
`endif

    logic [15:0] rom [32];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [4:0] base;
        logic [5:0] len;
        int         stall_at;
        int         stall_len;
        int         restart_at;
        int         loop_words;
        int         exp_words;
        logic [4:0] exp_addr;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    // Registered ROM model, one cycle of read latency.
    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    twiddle_fetch_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
`ifdef TW_LOOP_EN
        .loop     (loop_drv),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tw_data  (tw_data),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_seq(input vec_t v);
        int          c;
        int          words;
        int          first_cyc;
        int          last_cyc;
        int          done_cnt;
        int          done_cyc;
        int          valid_cnt;
        logic        late_bad;
        logic        holding;
        logic [15:0] held;
        logic [15:0] exp_w;

        @(posedge clk); #1;
        start    = 1'b1;
        base     = v.base;
        len      = v.len;
        tw_ready = 1'b1;
`ifdef TW_LOOP_EN
        loop_drv = (v.loop_words > 0);
`endif
        for (int i = 0; i < v.exp_words; i++) begin
            exp_q.push_back(rom[5'(int'(v.base) + (i % int'(v.len)))]);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        c         = 0;
        words     = 0;
        first_cyc = -1;
        last_cyc  = -1;
        done_cnt  = 0;
        done_cyc  = -1;
        valid_cnt = 0;
        late_bad  = 1'b0;
        holding   = 1'b0;
        held      = '0;
        while (c < 300 && (done_cyc < 0 || c <= done_cyc + 4)) begin
            tw_ready = !(c >= v.stall_at && c < v.stall_at + v.stall_len);
`ifdef TW_LOOP_EN
            loop_drv = (v.loop_words > 0) && (words < v.loop_words - int'(v.len));
`endif
            if (c == v.restart_at) begin
                start = 1'b1;
                base  = 5'd16;
                len   = 6'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (c == 0) check("busy_after_start", 32'(busy), 32'(v.len != 0));
            if (tw_valid) begin
                valid_cnt++;
                if (holding) check("stall_hold", 32'(tw_data), 32'(held));
                if (tw_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 32'(tw_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("word", 32'(tw_data), 32'(exp_w));
                    end
                    words++;
                    if (first_cyc < 0) first_cyc = c;
                    last_cyc = c;
                    holding  = 1'b0;
                end else begin
                    held    = tw_data;
                    holding = 1'b1;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                check("done_busy_low", 32'(busy), 32'd0);
            end
            if (done_cyc >= 0 && c > done_cyc && (busy || tw_valid)) late_bad = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        start    = 1'b0;
        tw_ready = 1'b1;
`ifdef TW_LOOP_EN
        loop_drv = 1'b0;
`endif
        check("no_timeout", 32'(c < 300), 32'd1);
        check("word_count", 32'(words), 32'(v.exp_words));
        check("done_count", 32'(done_cnt), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_after_done", 32'(late_bad), 32'd0);
        check("rom_addr_final", 32'(rom_addr), 32'(v.exp_addr));
        if (v.exp_words > 0) begin
            check("first_valid_cycle", 32'(first_cyc), 32'd2);
            check("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
            if (v.stall_len == 0)
                check("throughput", 32'(last_cyc), 32'(first_cyc + v.exp_words - 1));
        end else begin
            check("no_valid_len0", 32'(valid_cnt), 32'd0);
            check("done_cycle_len0", 32'(done_cyc), 32'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 5; i++) rom[i] = 16'h0100;
        rom[5]  = 16'h0000;  rom[6]  = 16'h0100;  rom[7]  = 16'h0000;
        rom[9]  = 16'h00B5;  rom[10] = 16'h0000;  rom[11] = 16'hFF4A;  rom[12] = 16'hFF9E;
        rom[16] = 16'h00B5;  rom[17] = 16'h008E;  rom[18] = 16'h0061;  rom[19] = 16'h0031;
        rom[30] = 16'h0000;  rom[31] = 16'h0000;

        //           base   len    st_at st_len rst_at loop exp_w exp_addr
        vecs.push_back('{5'd0,  6'd8,  -1, 0, -1, 0, 8,  5'd7});
        vecs.push_back('{5'd9,  6'd4,  3,  3, -1, 0, 4,  5'd12});
        vecs.push_back('{5'd5,  6'd0,  -1, 0, -1, 0, 0,  5'd12});
        vecs.push_back('{5'd30, 6'd4,  -1, 0, -1, 0, 4,  5'd1});
        vecs.push_back('{5'd0,  6'd32, -1, 0, -1, 0, 32, 5'd31});
        vecs.push_back('{5'd3,  6'd4,  -1, 0, 3,  0, 4,  5'd6});
        vecs.push_back('{5'd7,  6'd2,  -1, 0, 4,  0, 2,  5'd8});
        vecs.push_back('{5'd20, 6'd1,  -1, 0, -1, 0, 1,  5'd20});
`ifdef TW_LOOP_EN
        vecs.push_back('{5'd16, 6'd4,  -1, 0, -1, 12, 12, 5'd19});
        loop_drv = 1'b0;
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        base     = '0;
        len      = '0;
        tw_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_tw_data", 32'(tw_data), 32'd0);
        check("reset_tw_valid", 32'(tw_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Abort a sweep with the FIFO full and ready low; reset must clear outputs immediately.
        @(posedge clk); #1;
        start    = 1'b1;
        base     = 5'd0;
        len      = 6'd16;
        tw_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(tw_valid), 32'd1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_data", 32'(tw_data), 32'h0100);
        rst_n = 1'b0;
        #1;
        check("async_rom_addr", 32'(rom_addr), 32'd0);
        check("async_tw_data", 32'(tw_data), 32'd0);
        check("async_tw_valid", 32'(tw_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        tw_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_no_done", 32'(done), 32'd0);

        foreach (vecs[k]) run_seq(vecs[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
